// File: rtl/sram_pkg.sv
// Shared sizing constants and word type for the 256x8 scratch RAM.
package sram_pkg;

   localparam int unsigned SRAM_DATA_WIDTH = 8;
   localparam int unsigned SRAM_ADDR_WIDTH = 8;
   localparam int unsigned SRAM_DEPTH      = 2 ** SRAM_ADDR_WIDTH;

   typedef logic [SRAM_DATA_WIDTH-1:0] word_t;

endpackage : sram_pkg

// File: rtl/sram_array.sv
// Bare storage: synchronous write port, combinational read port.
// There is no reset; contents survive the block reset.
module sram_array
   import sram_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = SRAM_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = SRAM_ADDR_WIDTH,
   parameter int unsigned DEPTH      = SRAM_DEPTH
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] rd_data_c
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[addr] <= wr_data;
      end
   end

   assign rd_data_c = mem_q[addr];

endmodule : sram_array

// File: rtl/sram.sv
// Single-port synchronous RAM: enable decode plus a resettable read register.
// A write wins over a simultaneous read; the read register then holds.
module sram
   import sram_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = SRAM_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = SRAM_ADDR_WIDTH,
   parameter int unsigned DEPTH      = 2 ** ADDR_WIDTH
) (
   input  logic                  Clock,
   input  logic                  Reset_n,
   input  logic [DATA_WIDTH-1:0] dataIn,
   output logic [DATA_WIDTH-1:0] dataOut,
   input  logic [ADDR_WIDTH-1:0] Addr,
   input  logic                  ChipSelect,
   input  logic                  WriteEnable,
   input  logic                  ReadEnable
);

   logic                  wr_en_c;
   logic                  rd_en_c;
   logic [DATA_WIDTH-1:0] rd_data_c;
   logic [DATA_WIDTH-1:0] dout_d;
   logic [DATA_WIDTH-1:0] dout_q;

   // Reset_n gates the write so an edge seen while in reset never commits.
   always_comb begin
      wr_en_c = 1'b0;
      rd_en_c = 1'b0;
      if (Reset_n && ChipSelect) begin
         wr_en_c = WriteEnable;
         rd_en_c = ReadEnable && !WriteEnable;
      end
   end

   sram_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_array (
      .clk       (Clock),
      .wr_en     (wr_en_c),
      .addr      (Addr),
      .wr_data   (dataIn),
      .rd_data_c (rd_data_c)
   );

   always_comb begin
      dout_d = dout_q;
      if (rd_en_c) begin
         dout_d = rd_data_c;
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         dout_q <= '0;
      end else begin
         dout_q <= dout_d;
      end
   end

   assign dataOut = dout_q;

endmodule : sram

// File: tb/tb_sram.sv
// Scoreboard bench for sram: stimulus queues the expected dataOut for each
// cycle, a monitor pops and compares after the matching clock edge.
module tb_sram;
   import sram_pkg::*;

   logic  Clock;
   logic  Reset_n;
   word_t dataIn;
   word_t dataOut;
   logic [SRAM_ADDR_WIDTH-1:0] Addr;
   logic  ChipSelect;
   logic  WriteEnable;
   logic  ReadEnable;

   int total = 0;
   int bad   = 0;
   int cyc_cnt = 0;

   typedef struct {
      int    cyc;
      word_t val;
      string name;
   } exp_t;

   exp_t exp_q[$];

   sram dut (
      .Clock       (Clock),
      .Reset_n     (Reset_n),
      .dataIn      (dataIn),
      .dataOut     (dataOut),
      .Addr        (Addr),
      .ChipSelect  (ChipSelect),
      .WriteEnable (WriteEnable),
      .ReadEnable  (ReadEnable)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   always @(posedge Clock) cyc_cnt <= cyc_cnt + 1;

   // Monitor: compare every expectation due at this edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge Clock);
         #2;
         while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
            e = exp_q.pop_front();
            total++;
            if (e.cyc < cyc_cnt) begin
               bad++;
               $display("FAIL %s: expectation for cycle %0d not checked in time (now %0d)",
                        e.name, e.cyc, cyc_cnt);
            end else if (dataOut !== e.val) begin
               bad++;
               $display("FAIL %s: dataOut=%02h expected=%02h (cycle %0d)",
                        e.name, dataOut, e.val, cyc_cnt);
            end
         end
      end
   end

   task automatic check_now(input string name, input word_t expv);
      total++;
      if (dataOut !== expv) begin
         bad++;
         $display("FAIL %s: dataOut=%02h expected=%02h", name, dataOut, expv);
      end
   endtask

   // Drive one access at the falling edge; dataOut after the next rising edge must equal expv.
   task automatic do_cycle(input logic cs, input logic we, input logic re,
                           input logic [7:0] a, input word_t din,
                           input word_t expv, input string name);
      exp_t e;
      @(negedge Clock);
      ChipSelect  = cs;
      WriteEnable = we;
      ReadEnable  = re;
      Addr        = a;
      dataIn      = din;
      e.cyc  = cyc_cnt + 1;
      e.val  = expv;
      e.name = name;
      exp_q.push_back(e);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() > 0 && n < 20) begin
         @(posedge Clock);
         n++;
      end
      #3;
      if (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d expectations never checked", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      word_t wr_vals[5];
      wr_vals = '{8'h00, 8'h01, 8'h10, 8'h06, 8'h12};

      Reset_n = 1'b0;
      ChipSelect = 1'b0;
      WriteEnable = 1'b0;
      ReadEnable = 1'b0;
      Addr = '0;
      dataIn = '0;

      repeat (3) @(negedge Clock);
      check_now("reset_hold", 8'h00);
      Reset_n = 1'b1;

      for (int i = 0; i < 5; i++)
         do_cycle(1, 1, 0, 8'(i), wr_vals[i], 8'h00, "write_hold");
      for (int i = 0; i < 5; i++)
         do_cycle(1, 0, 1, 8'(i), 8'h00, wr_vals[i], "read_back");

      do_cycle(0, 1, 0, 8'h02, 8'hFF, 8'h12, "cs_low_write");
      do_cycle(1, 0, 1, 8'h02, 8'h00, 8'h10, "cs_low_write_blocked");
      do_cycle(0, 0, 1, 8'h04, 8'h00, 8'h10, "cs_low_read_hold");

      do_cycle(1, 1, 1, 8'h03, 8'hA5, 8'h10, "both_en_hold");
      do_cycle(1, 0, 1, 8'h03, 8'h00, 8'hA5, "both_en_write");

      do_cycle(1, 1, 0, 8'hFF, 8'h5A, 8'hA5, "wr_top_hold");
      do_cycle(1, 1, 0, 8'h00, 8'hC3, 8'hA5, "wr_bot_hold");
      do_cycle(1, 0, 1, 8'hFF, 8'h00, 8'h5A, "read_top");
      do_cycle(1, 0, 1, 8'h00, 8'h00, 8'hC3, "read_bot");
      do_cycle(1, 0, 1, 8'h04, 8'h00, 8'h12, "read_pre_reset");
      drain();

      // Mid-cycle reset with a write to 0x01 presented across the edge.
      @(negedge Clock);
      ChipSelect  = 1'b1;
      WriteEnable = 1'b1;
      ReadEnable  = 1'b0;
      Addr        = 8'h01;
      dataIn      = 8'hEE;
      #1;
      Reset_n = 1'b0;
      #1;
      check_now("async_reset", 8'h00);
      @(posedge Clock);
      #2;
      check_now("reset_edge_hold", 8'h00);
      @(negedge Clock);
      Reset_n = 1'b1;
      ChipSelect = 1'b0;
      WriteEnable = 1'b0;

      do_cycle(0, 0, 0, 8'h01, 8'h00, 8'h00, "post_reset_idle");
      do_cycle(1, 0, 1, 8'h01, 8'h00, 8'h01, "post_reset_retained");
      do_cycle(0, 0, 0, 8'h00, 8'h00, 8'h01, "idle_hold");
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule : tb_sram

// File: doc/sram.md
Name: sram

Overview:
- Single-port synchronous static RAM, 256 words x 8 bits, one clock domain.
- Local scratch storage for datapath blocks, addressed by an 8-bit address.
- Access is gated by a chip select plus separate write and read enables.
- Writes commit on the rising clock edge; reads return registered data one cycle after the address is sampled.

Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 8, address width in bits.
- DEPTH, 2**ADDR_WIDTH (256), number of words; must equal 2**ADDR_WIDTH.

Ports:
- Clock  input  1  system clock; all state changes on its rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- dataIn  input  DATA_WIDTH  write data.
- dataOut  output  DATA_WIDTH  registered read data.
- Addr  input  ADDR_WIDTH  word address for read or write.
- ChipSelect  input  1  active-high enable; when low, no access occurs.
- WriteEnable  input  1  active-high write request.
- ReadEnable  input  1  active-high read request.

Behaviour:
- Interface:
  - One clock (Clock).
  - Reset (Reset_n) is asynchronous and active-low.
- Reset:
  - Reset_n low forces dataOut to 0 immediately, independent of Clock, and holds it there while low.
  - Memory array contents are not reset. They are undefined after power-up and preserved across reset.
  - Accesses are ignored while Reset_n is low.
- Write:
  - On a rising edge with ChipSelect=1 and WriteEnable=1, mem[Addr] <= dataIn.
  - New data is visible to a read sampled on any later edge.
- Read:
  - On a rising edge with ChipSelect=1, ReadEnable=1 and WriteEnable=0, dataOut <= mem[Addr].
  - Latency is 1 cycle: the address presented before edge N appears on dataOut after edge N.
  - Back-to-back reads on consecutive cycles are allowed, giving one word per cycle.
- Simultaneous WriteEnable=1 and ReadEnable=1 with ChipSelect=1:
  - The write executes.
  - The read is suppressed and dataOut holds its previous value.
- Idle (ChipSelect=0, or both enables 0):
  - Memory is unchanged.
  - dataOut holds its last value; there is no tri-state and no return to 0.
- Addressing:
  - All 256 addresses are valid. There is no wrap or out-of-range case, since Addr width equals log2(DEPTH).
- Reset mid-operation:
  - A write on the same edge that Reset_n is low is dropped.
  - After release, the first access takes effect on the first rising edge with Reset_n high.
- No handshake or ready signal; the block accepts an access every cycle.

Decomposition:
- Package sram_pkg: DATA_WIDTH and ADDR_WIDTH defaults, DEPTH constant, and a word typedef (logic [DATA_WIDTH-1:0]).
- One sub-module is natural: sram_array, holding the bare storage (mem array, synchronous write port, combinational or registered read port) with no reset.
- Top-level sram owns the enable decoding and the resettable dataOut register.

Test Plan:
- Reset: hold Reset_n=0 with ChipSelect=0 -> dataOut=0x00. Assert Reset_n=0 mid-cycle after dataOut=0x12 -> dataOut=0x00 immediately, before the next clock edge.
- Write then read sequence:
  - Stimulus: ChipSelect=1, WriteEnable=1; write Addr 0..4 with 0x00, 0x01, 0x10, 0x06, 0x12, one per cycle. Then WriteEnable=0, ReadEnable=1; read Addr 0..4 one per cycle.
  - Required response: dataOut equals 0x00, 0x01, 0x10, 0x06, 0x12, each one cycle after its address.
- Chip select gating: ChipSelect=0, WriteEnable=1, Addr=0x02, dataIn=0xFF, then a normal read of 0x02 -> 0x10 (unchanged). ChipSelect=0 with ReadEnable=1 -> dataOut holds its prior value.
- Simultaneous enables: ChipSelect=1, WriteEnable=1, ReadEnable=1, Addr=0x03, dataIn=0xA5 -> dataOut unchanged that cycle; a later read of 0x03 -> 0xA5.
- Boundary addresses: write 0x5A to 0xFF and 0xC3 to 0x00, then read 0xFF then 0x00 -> 0x5A then 0xC3.
- Reset persistence: after the writes above, pulse Reset_n low for one cycle, then read 0x01 -> 0x01 (memory retained); dataOut is 0x00 until that read completes.
